// File: rtl/run_halt_dumper_if.sv
// Dump stream channel between the run monitor and the sink.
// The monitor sends one beat per handshake.
//   dump_valid : beat valid (master -> slave)
//   dump_ready : sink accepts the beat (slave -> master)
//   dump_is_pc : the beat carries the final PC
//   dump_index : register index of the beat (0 on the PC beat)
//   dump_data  : beat payload
interface run_halt_dumper_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              dump_valid;
  logic              dump_ready;
  logic              dump_is_pc;
  logic [ADDR_W-1:0] dump_index;
  logic [DATA_W-1:0] dump_data;

  modport master (
    output dump_valid, dump_is_pc, dump_index, dump_data,
    input  dump_ready
  );

  modport slave (
    input  dump_valid, dump_is_pc, dump_index, dump_data,
    output dump_ready
  );
endinterface

// File: rtl/run_halt_dumper.sv
// Run monitor for the MIPS core. It counts RUN cycles and watches the PC.
// A run ends in one of two ways:
//   - halt: the PC stays unchanged for HALT_REPEAT comparisons in a row
//   - timeout: the RUN-cycle budget runs out
// When the run ends, the CPU is held. The final PC and then every
// register-file entry are streamed out over the dump channel.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   i_start       : begin a run (only honoured in IDLE or DONE)
//   i_pc          : CPU program counter
//   o_cpu_hold    : stall request to the CPU
//   o_rf_raddr    : register-file read address
//   i_rf_rdata    : register-file read data (combinational from the address)
//   dump          : dump stream (master side)
//   o_busy        : run or dump in progress
//   o_done        : dump complete
//   o_timeout     : run ended by the cycle budget
//   o_cycle_count : RUN cycles elapsed; frozen when RUN is left
module run_halt_dumper #(
  parameter int DATA_W      = 32,
  parameter int NREG        = 32,
  parameter int ADDR_W      = 5,
  parameter int PC_W        = 32,
  parameter int MAX_CYCLES  = 4096,
  parameter int HALT_REPEAT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [PC_W-1:0]    i_pc,
  output logic               o_cpu_hold,
  output logic [ADDR_W-1:0]  o_rf_raddr,
  input  logic [DATA_W-1:0]  i_rf_rdata,
  run_halt_dumper_if.master  dump,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_timeout,
  output logic [31:0]        o_cycle_count
);

  // The stability counter only has to reach HALT_REPEAT.
  localparam int SW = $clog2(HALT_REPEAT + 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_LOAD, S_SEND, S_DONE} state_t;

  state_t            r_state;
  logic [PC_W-1:0]   r_prev_pc;
  logic [PC_W-1:0]   r_final_pc;
  logic [SW-1:0]     r_stable_cnt;
  logic              r_first;
  logic              r_beat_pc;    // current beat is the PC beat
  logic [ADDR_W-1:0] r_idx;        // register index of the current beat
  logic [31:0]       r_cycle_count;
  logic              r_cpu_hold;
  logic              r_busy;
  logic              r_done;
  logic              r_timeout;
  logic              r_dump_valid;
  logic              r_dump_is_pc;
  logic [ADDR_W-1:0] r_dump_index;
  logic [DATA_W-1:0] r_dump_data;

  logic w_same_pc;
  logic w_halt_hit;
  logic w_to_hit;
  logic w_last_beat;

  // prev_pc is meaningless on the first RUN cycle, so that cycle never counts as "unchanged".
  assign w_same_pc   = !r_first && (i_pc == r_prev_pc);
  assign w_halt_hit  = w_same_pc && (r_stable_cnt == SW'(HALT_REPEAT - 1));
  assign w_to_hit    = (r_cycle_count == 32'(MAX_CYCLES - 1));
  assign w_last_beat = !r_beat_pc && (r_idx == ADDR_W'(NREG - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_prev_pc     <= '0;
      r_final_pc    <= '0;
      r_stable_cnt  <= '0;
      r_first       <= 1'b0;
      r_beat_pc     <= 1'b0;
      r_idx         <= '0;
      r_cycle_count <= '0;
      r_cpu_hold    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
      r_dump_valid  <= 1'b0;
      r_dump_is_pc  <= 1'b0;
      r_dump_index  <= '0;
      r_dump_data   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state       <= S_RUN;
            r_cycle_count <= '0;
            r_stable_cnt  <= '0;
            r_first       <= 1'b1;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_cpu_hold    <= 1'b0;
            r_busy        <= 1'b1;
          end
        end
        S_RUN: begin
          r_cycle_count <= r_cycle_count + 32'd1;
          r_prev_pc     <= i_pc;
          r_first       <= 1'b0;
          r_stable_cnt  <= w_same_pc ? r_stable_cnt + SW'(1) : '0;
          if (w_halt_hit || w_to_hit) begin
            r_state    <= S_LOAD;
            r_final_pc <= i_pc;
            r_cpu_hold <= 1'b1;
            // If halt and timeout happen on the same cycle, the run counts as a halt.
            r_timeout  <= w_to_hit && !w_halt_hit;
            r_beat_pc  <= 1'b1;
            r_idx      <= '0;
          end
        end
        S_LOAD: begin
          // During LOAD, the register file sees r_idx on o_rf_raddr.
          if (r_beat_pc) begin
            r_dump_data  <= DATA_W'(r_final_pc);
            r_dump_is_pc <= 1'b1;
            r_dump_index <= '0;
          end else begin
            r_dump_data  <= i_rf_rdata;
            r_dump_is_pc <= 1'b0;
            r_dump_index <= r_idx;
          end
          r_dump_valid <= 1'b1;
          r_state      <= S_SEND;
        end
        S_SEND: begin
          if (dump.dump_ready) begin
            r_dump_valid <= 1'b0;
            if (r_beat_pc) begin
              r_beat_pc <= 1'b0;
              r_idx     <= '0;
              r_state   <= S_LOAD;
            end else if (w_last_beat) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_idx   <= r_idx + ADDR_W'(1);
              r_state <= S_LOAD;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_cpu_hold      = r_cpu_hold;
  assign o_rf_raddr      = r_idx;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_timeout       = r_timeout;
  assign o_cycle_count   = r_cycle_count;
  assign dump.dump_valid = r_dump_valid;
  assign dump.dump_is_pc = r_dump_is_pc;
  assign dump.dump_index = r_dump_index;
  assign dump.dump_data  = r_dump_data;

endmodule

// File: doc/run_halt_dumper.md
Name: run_halt_dumper

Overview:
Synthesizable run monitor for the MIPS core. It replaces fixed-delay simulation runs with halt detection plus a cycle-budget timeout. After the run ends, it freezes the CPU and streams the final PC and every register-file entry out over a valid/ready channel. It sits beside the CPU, watches the PC, and uses a spare register-file read port.

Parameters:
DATA_W, 32, register and dump data width
NREG, 32, register-file entries dumped (indices 0..NREG-1)
ADDR_W, 5, register index width; NREG <= 2**ADDR_W
PC_W, 32, PC width; PC_W <= DATA_W
MAX_CYCLES, 4096, RUN-cycle budget before timeout (>= 2)
HALT_REPEAT, 3, consecutive unchanged-PC comparisons that declare halt (>= 1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  begin a run; honoured only in IDLE or DONE
pc  in  PC_W  current CPU program counter
cpu_hold  out  1  stall request to the CPU; high from the halt/timeout edge until start or rst
rf_raddr  out  ADDR_W  register-file read address
rf_rdata  in  DATA_W  register-file read data, combinational from rf_raddr
dump_valid  out  1  dump beat valid
dump_ready  in  1  sink accepts beat
dump_is_pc  out  1  current beat carries the final PC
dump_index  out  ADDR_W  register index of the beat (0 on the PC beat)
dump_data  out  DATA_W  beat payload
busy  out  1  high outside IDLE and DONE
done  out  1  dump complete; held until start or rst
timeout  out  1  run ended by budget, not by halt; held until start or rst
cycle_count  out  32  RUN cycles elapsed; frozen on exit from RUN

Behaviour:
- Reset: state IDLE; every output, including rf_raddr and cycle_count, is 0; internal prev_pc, stable_cnt and first flag are cleared. rst overrides everything in any state, including mid-RUN and mid-dump. A partially sent dump is abandoned and not resumed.
- States: IDLE, RUN, LOAD, SEND, DONE.
- IDLE/DONE with start=1: go to RUN. Clear cycle_count, stable_cnt, done, timeout and cpu_hold. Set first=1.
- start in RUN, LOAD or SEND is ignored.
- RUN, on each edge:
  - cycle_count+1
  - prev_pc<=pc
  - first<=0
  - stable_cnt<=(!first && pc==prev_pc) ? stable_cnt+1 : 0
- halt_hit = !first && pc==prev_pc && stable_cnt==HALT_REPEAT-1.
- to_hit = cycle_count==MAX_CYCLES-1.
- If halt_hit or to_hit on an edge, the FSM goes to LOAD on that edge. It latches final_pc=pc, sets cpu_hold=1, sets timeout=to_hit&&!halt_hit (halt wins a tie), and sets beat index to PC.
- LOAD (1 cycle):
  - PC beat: dump_data<=zero-extended final_pc, dump_is_pc<=1, dump_index<=0.
  - Register beat: rf_raddr holds idx; dump_data<=rf_rdata, dump_is_pc<=0, dump_index<=idx.
  - Next state is SEND.
- SEND: dump_valid=1. dump_data, dump_index and dump_is_pc are stable while dump_ready=0.
- On dump_valid&&dump_ready:
  - After the PC beat, idx=0.
  - After a register beat, idx+1.
  - If the beat was register NREG-1, go to DONE with done=1 and dump_valid=0; otherwise go to LOAD.
- Minimum 2 cycles per beat; NREG+1 beats total, in order PC, r0..r(NREG-1).
- cycle_count wraps at 2^32, irrelevant because MAX_CYCLES bounds it.
- DONE: cpu_hold stays 1; outputs hold until start or rst.

Test Plan:
1. Default parameters, start at cycle 0. pc = 0,4,…,0x3C on RUN cycles 0..15, then 0x3C constant. Required: halt on RUN cycle 18, cycle_count=19, cpu_hold=1, timeout=0. First beat has is_pc=1, data=0x3C.
2. MAX_CYCLES=64, pc increments by 4 every cycle. Required: exit on RUN cycle 63, cycle_count=64, timeout=1, final PC beat data=0xFC.
3. Register file preloaded with reg[i]=i*0x11, dump_ready tied 1. Required: 33 beats, indices 0..31 after the PC beat, data i*0x11, done after last beat, 66 cycles from LOAD entry to DONE.
4. dump_ready held 0 for 5 cycles on the reg 8 beat. Required: dump_valid=1, dump_index=8 and dump_data=0x88 held stable, then ordering resumes at 9.
5. NREG=4, ADDR_W=2. Required: 5 beats, then done. rst pulsed during the reg 2 beat of a rerun: all outputs 0 next cycle, state IDLE.
6. start pulsed during RUN: ignored. start in DONE: done, timeout and cpu_hold clear, cycle_count restarts at 0.
